psram_cfg_arb: RTL
==================

Name: psram_cfg_arb

Overview:
- Round-robin arbiter and sequencer that shares the single PSRAM core config-register path among NUM_REQ requesters, e.g. the boot init engine, the APB CSR bridge and the debug port.
- Accepts one register read/write at a time, launches it into the core as a one-cycle cfg_wr/cfg_rd pulse, and waits for the core's done.
- Returns read data, or a timeout error, to the granted requester.
- Enforces a minimum CE-high gap between consecutive transactions.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYC, 8, clk_i cycles between completion and the next possible grant (0 allowed).
- TIMEOUT, 1024, max clk_i cycles in WAIT before abort (>=4).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- arb_en_i  in  1  when 0, no new grants are issued; an in-flight transaction still completes.
- req_i  in  NUM_REQ  per-requester request, level; payload must be stable while req=1.
- we_i  in  NUM_REQ  per-requester: 1 = register write, 0 = register read.
- addr_i  in  8*NUM_REQ  per-requester register address; slice k = [8k+7:8k].
- wdata_i  in  8*NUM_REQ  per-requester write data.
- gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: request accepted; requester may drop req next cycle.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished.
- rsp_err_o  out  1  qualifies rsp_valid_o: 1 = timeout.
- rdata_o  out  8  read data, valid with rsp_valid_o on a read; holds its value otherwise.
- busy_o  out  1  FSM not in IDLE.
- core_en_o  out  1  to core en.
- core_cflg_o  out  1  to core cflg; tied high while the FSM is not IDLE.
- core_cfg_wr_o  out  1  one-cycle write launch.
- core_cfg_rd_o  out  1  one-cycle read launch.
- core_ma_o  out  8  latched address.
- core_data_o  out  8  latched write data.
- core_done_i  in  1  core done (level; may already be high when idle).
- core_rdata_i  in  8  core read-back byte.

Behaviour:
- Reset (rst_i=1 at a clock edge, any state including mid-transaction):
  - FSM=IDLE.
  - All outputs 0.
  - Latched cmd/addr/data cleared.
  - RR pointer last_gnt=NUM_REQ-1, so requester 0 has top priority.
  - Timeout and gap counters 0.
  - A core transaction in flight is abandoned; no rsp_valid is issued for it.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If arb_en_i and |req_i, winner k = first set req scanning last_gnt+1, last_gnt+2, ... modulo NUM_REQ.
  - Latch we/addr/wdata of k and set last_gnt=k.
  - Next state ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt_o[k]=1.
  - core_cfg_wr_o=we, core_cfg_rd_o=~we.
  - Timeout counter cleared.
  - Next state WAIT.
- WAIT:
  - done_q = core_done_i registered.
  - Completion = core_done_i & ~done_q (rising edge). A level already high at entry is ignored until it falls and rises again.
  - On completion: next cycle rsp_valid_o[k]=1, rsp_err_o=0, rdata_o=core_rdata_i sampled at the completion edge on a read; rdata_o unchanged on a write.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without completion: rsp_valid_o[k]=1 and rsp_err_o=1 next cycle, rdata_o unchanged.
  - Either exit goes to GAP, or to IDLE if GAP_CYC=0.
  - Completion and timeout in the same cycle: completion wins (err=0).
- GAP: counts GAP_CYC cycles, then IDLE.
  - Sequence is: rsp_valid cycle = first GAP cycle; earliest next ISSUE is GAP_CYC+1 cycles after rsp_valid.
- Core-side outputs while FSM is not IDLE:
  - core_en_o=1 and core_cflg_o=1.
  - core_ma_o and core_data_o hold the latched values.
- Grant to an idle FSM: 1 cycle from req to ISSUE/gnt. Requests arriving during ISSUE/WAIT/GAP wait; they are not lost while req is held.
- arb_en_i falling during WAIT: the transaction completes normally; no new grant is issued afterwards.
- req_i dropped before grant: that requester is not served. A requester that drops req after gnt still receives rsp_valid.
- At most one transaction in flight. gnt_o and rsp_valid_o are never asserted together.

Test Plan:
- Single write, req_i=3'b001, we=1, addr=0x04, wdata=0xA5, core done rises 20 cycles after launch -> gnt_o=001 one cycle; core_cfg_wr_o one pulse with core_ma_o=0x04 and core_data_o=0xA5; rsp_valid_o=001, rsp_err_o=0 one cycle after the done edge.
- Read from requester 2, core_rdata_i=0x5C at the done edge -> rsp_valid_o=100, rdata_o=0x5C; rdata_o holds 0x5C afterwards.
- Fairness, req_i=3'b111 held continuously -> grant order 0,1,2,0,1,2; back-to-back rsp_valid/ISSUE spacing exactly GAP_CYC+1 cycles.
- Timeout, core_done_i stuck at 0 (and a separate run with it stuck at 1 from before launch) -> rsp_valid with rsp_err_o=1 exactly TIMEOUT cycles after entering WAIT; next grant proceeds normally.
- rst_i asserted in the middle of WAIT -> next cycle all outputs 0, busy_o=0, no rsp_valid issued; with 3'b110 requesting after reset, requester 1 is granted first.
- arb_en_i=0 with req_i=3'b010 -> no gnt for 50 cycles; arb_en_i=1 -> gnt_o=010 on the second cycle after.

Source files
------------

// File: rtl/psram_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : psram_cfg_arb
// Purpose  : Round-robin arbiter and sequencer sharing the single PSRAM core
//            config-register path between NUM_REQ requesters. Launches one
//            register read/write at a time, waits for the core done edge or
//            a timeout, returns the response and then enforces a CE-high gap.
// Revision : 1.0 - initial release
// ============================================================================
module psram_cfg_arb #(
    parameter int NUM_REQ = 3,     // number of requesters (2..8)
    parameter int GAP_CYC = 8,     // idle cycles after a response (0 allowed)
    parameter int TIMEOUT = 1024   // max cycles spent waiting for done (>=4)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arb_en_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   we_i,
    input  logic [8*NUM_REQ-1:0] addr_i,
    input  logic [8*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic                 rsp_err_o,
    output logic [7:0]           rdata_o,
    output logic                 busy_o,
    output logic                 core_en_o,
    output logic                 core_cflg_o,
    output logic                 core_cfg_wr_o,
    output logic                 core_cfg_rd_o,
    output logic [7:0]           core_ma_o,
    output logic [7:0]           core_data_o,
    input  logic                 core_done_i,
    input  logic [7:0]           core_rdata_i
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int C_IDX_W = $clog2(NUM_REQ);
    localparam int C_SUM_W = C_IDX_W + 1;          // holds last_gnt + NUM_REQ
    localparam int C_TMO_W = $clog2(TIMEOUT);
    localparam int C_GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [C_IDX_W-1:0] C_LAST_RST = C_IDX_W'(NUM_REQ - 1);
    localparam logic [C_SUM_W-1:0] C_NUM_REQ  = C_SUM_W'(NUM_REQ);
    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);
    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [C_IDX_W-1:0]   last_gnt_q,  last_gnt_d;
    logic                 we_q,        we_d;
    logic [7:0]           addr_q,      addr_d;
    logic [7:0]           wdata_q,     wdata_d;
    logic [C_TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
    logic [C_GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic                 done_q,      done_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q,   rsp_err_d;
    logic [7:0]           rdata_q,     rdata_d;

    // Arbitration scan results
    logic                 pick_found;
    logic [C_IDX_W-1:0]   pick_idx;
    logic [C_SUM_W-1:0]   scan_sum;
    logic [C_IDX_W-1:0]   scan_idx;

    // Misc decode
    logic                 done_rise;
    logic [NUM_REQ-1:0]   sel_onehot;

    // A done level already high on WAIT entry is not a completion: only a
    // fresh 0->1 transition counts.
    assign done_rise  = core_done_i & ~done_q;

    // The granted requester index lives in last_gnt for the whole transaction.
    assign sel_onehot = NUM_REQ'(1) << last_gnt_q;

    // Round-robin scan starting one past the previous winner, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_gnt_q;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_sum = {1'b0, last_gnt_q} + C_SUM_W'(i);
            if (scan_sum >= C_NUM_REQ) begin
                scan_sum = scan_sum - C_NUM_REQ;
            end
            scan_idx = scan_sum[C_IDX_W-1:0];
            if (!pick_found && req_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Next-state, counters, command latch and response generation.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = core_done_i;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_en_i && pick_found) begin
                    last_gnt_d = pick_idx;
                    we_d       = we_i[pick_idx];
                    addr_d     = addr_i[{pick_idx, 3'b000} +: 8];
                    wdata_d    = wdata_i[{pick_idx, 3'b000} +: 8];
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end

            ST_WAIT: begin
                // Completion takes precedence over a coincident timeout.
                if (done_rise || (tmo_cnt_q == C_TMO_LAST)) begin
                    rsp_valid_d = sel_onehot;
                    rsp_err_d   = ~done_rise;
                    if (done_rise && !we_q) begin
                        rdata_d = core_rdata_i;
                    end
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                // The response pulse coincides with the first GAP cycle.
                if (gap_cnt_q == C_GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight core transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= C_LAST_RST;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so none depend on inputs
    // combinationally.
    // ------------------------------------------------------------------------
    assign busy_o        = (state_q != ST_IDLE);
    assign gnt_o         = (state_q == ST_ISSUE) ? sel_onehot : '0;
    assign core_cfg_wr_o = (state_q == ST_ISSUE) &  we_q;
    assign core_cfg_rd_o = (state_q == ST_ISSUE) & ~we_q;
    assign core_en_o     = busy_o;
    assign core_cflg_o   = busy_o;
    assign core_ma_o     = addr_q;
    assign core_data_o   = wdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rdata_o       = rdata_q;

endmodule
`default_nettype wire
